// File: rtl/obstacle_engine_if.sv
// rtl/obstacle_engine_if.sv - sequencer/renderer-facing signal bundle for obstacle_engine
interface obstacle_engine_if #(
  parameter int NUM_OBS = 4
);
  logic                   run;
  logic                   frame_tick;
  logic [2:0]             level;
  logic [9:0]             player_y;
  logic [10:0]            game_time;
  logic [10:0]            obj_count;
  logic                   playerDied;
  logic [11*NUM_OBS-1:0]  obs_x;

  modport master (
    output run, frame_tick, level, player_y,
    input  game_time, obj_count, playerDied, obs_x
  );

  modport slave (
    input  run, frame_tick, level, player_y,
    output game_time, obj_count, playerDied, obs_x
  );
endinterface

// File: rtl/obstacle_engine.sv
// rtl/obstacle_engine.sv - scrolls obstacles per frame, counts time/passes, detects player collision
module obstacle_engine #(
  parameter int NUM_OBS         = 4,
  parameter int SCREEN_W        = 640,
  parameter int SPACING         = 160,
  parameter int FRAMES_PER_TICK = 6,
  parameter int PLAYER_X        = 64,
  parameter int PLAYER_W        = 16,
  parameter int PLAYER_H        = 24,
  parameter int OBS_W           = 16,
  parameter int OBS_H           = 20,
  parameter int GROUND_Y        = 400
) (
  input logic              clk,
  input logic              reset,
  obstacle_engine_if.slave io_bus
);

  localparam int          DIV_W   = (FRAMES_PER_TICK > 2) ? $clog2(FRAMES_PER_TICK) : 1;
  localparam int          CNT_W   = $clog2(NUM_OBS + 1);
  localparam logic [10:0] MAX_CNT = 11'd2047;

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DEAD} state_t;

  state_t             r_state, w_state_nxt;
  logic [10:0]        r_obs [NUM_OBS];
  logic [10:0]        w_obs_nxt [NUM_OBS];
  logic [10:0]        w_moved [NUM_OBS];
  logic [10:0]        r_game_time, w_game_time_nxt;
  logic [10:0]        r_obj_count, w_obj_count_nxt;
  logic [DIV_W-1:0]   r_div, w_div_nxt;
  logic               r_died, w_died_nxt;
  logic [1:0]         w_speed;
  logic               w_hit;
  logic [CNT_W-1:0]   w_pass_cnt;
  logic [11:0]        w_oc_sum;
  logic [10:0]        w_oc_sat;
  logic [10:0]        w_gt_inc;

  function automatic logic [10:0] f_init_x(input int idx);
    return 11'(SCREEN_W - 1 + idx * SPACING);
  endfunction

  always_comb begin
    case (io_bus.level)
      3'b001:  w_speed = 2'd1;
      3'b010:  w_speed = 2'd2;
      3'b100:  w_speed = 2'd3;
      default: w_speed = 2'd0;
    endcase
  end

  // Box overlap on pre-update positions, widened to 12 bits so sums cannot wrap
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < NUM_OBS; i++) begin
      if (({1'b0, r_obs[i]} < 12'(PLAYER_X + PLAYER_W)) &&
          (12'(PLAYER_X) < {1'b0, r_obs[i]} + 12'(OBS_W)) &&
          ({2'b0, io_bus.player_y} < 12'(GROUND_Y)) &&
          (12'(GROUND_Y - OBS_H) < {2'b0, io_bus.player_y} + 12'(PLAYER_H)))
        w_hit = 1'b1;
    end
  end

  always_comb begin
    w_pass_cnt = '0;
    for (int i = 0; i < NUM_OBS; i++) begin
      if (r_obs[i] < {9'd0, w_speed}) begin
        w_moved[i] = r_obs[i] + 11'(NUM_OBS * SPACING) - {9'd0, w_speed};
        w_pass_cnt = w_pass_cnt + CNT_W'(1);
      end else begin
        w_moved[i] = r_obs[i] - {9'd0, w_speed};
      end
    end
    w_oc_sum = {1'b0, r_obj_count} + 12'(w_pass_cnt);
    w_oc_sat = w_oc_sum[11] ? MAX_CNT : w_oc_sum[10:0];
    w_gt_inc = (r_game_time == MAX_CNT) ? MAX_CNT : r_game_time + 11'd1;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_obs_nxt       = r_obs;
    w_game_time_nxt = r_game_time;
    w_obj_count_nxt = r_obj_count;
    w_div_nxt       = r_div;
    w_died_nxt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (io_bus.run) w_state_nxt = S_PLAY;
      end
      S_PLAY: begin
        if (!io_bus.run) begin
          w_state_nxt     = S_IDLE;
          w_game_time_nxt = '0;
          w_obj_count_nxt = '0;
          w_div_nxt       = '0;
          for (int i = 0; i < NUM_OBS; i++) w_obs_nxt[i] = f_init_x(i);
        end else if (io_bus.frame_tick) begin
          if (w_hit) begin
            w_state_nxt = S_DEAD;
            w_died_nxt  = 1'b1;
          end else begin
            w_obs_nxt       = w_moved;
            w_obj_count_nxt = w_oc_sat;
            if (r_div == DIV_W'(FRAMES_PER_TICK - 1)) begin
              w_div_nxt       = '0;
              w_game_time_nxt = w_gt_inc;
            end else begin
              w_div_nxt = r_div + DIV_W'(1);
            end
          end
        end
      end
      S_DEAD: begin
        w_state_nxt     = io_bus.run ? S_PLAY : S_IDLE;
        w_game_time_nxt = '0;
        w_obj_count_nxt = '0;
        w_div_nxt       = '0;
        for (int i = 0; i < NUM_OBS; i++) w_obs_nxt[i] = f_init_x(i);
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_game_time <= '0;
      r_obj_count <= '0;
      r_div       <= '0;
      r_died      <= 1'b0;
      for (int i = 0; i < NUM_OBS; i++) r_obs[i] <= f_init_x(i);
    end else begin
      r_state     <= w_state_nxt;
      r_game_time <= w_game_time_nxt;
      r_obj_count <= w_obj_count_nxt;
      r_div       <= w_div_nxt;
      r_died      <= w_died_nxt;
      r_obs       <= w_obs_nxt;
    end
  end

  assign io_bus.game_time  = r_game_time;
  assign io_bus.obj_count  = r_obj_count;
  assign io_bus.playerDied = r_died;

  for (genvar g = 0; g < NUM_OBS; g++) begin : g_obs_out
    assign io_bus.obs_x[11*g +: 11] = r_obs[g];
  end

endmodule

// File: tb/tb_obstacle_engine.sv
// tb/tb_obstacle_engine.sv - randomized scoreboard bench for obstacle_engine
module tb_obstacle_engine;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  obstacle_engine_if #(.NUM_OBS(N)) bus ();

  obstacle_engine #(.NUM_OBS(N)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0]   gt;
    logic [10:0]   oc;
    logic          died;
    logic [11*N-1:0] obs;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // Reference model: mode 0 = idle, 1 = play, 2 = dead
  int m_mode, m_gt, m_oc, m_div, m_died;
  int m_x [N];

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic m_reload();
    for (int i = 0; i < N; i++) m_x[i] = 639 + 160 * i;
    m_gt = 0; m_oc = 0; m_div = 0;
  endtask

  task automatic step(input bit rst, input bit run, input bit tick,
                      input logic [2:0] lvl, input logic [9:0] py);
    int   spd, passed, px, py_i;
    bit   hit;
    exp_t e;
    @(negedge clk);
    reset = rst; bus.run = run; bus.frame_tick = tick; bus.level = lvl; bus.player_y = py;
    py_i = int'(py);
    spd = (lvl == 3'b001) ? 1 : (lvl == 3'b010) ? 2 : (lvl == 3'b100) ? 3 : 0;
    if (rst) begin
      m_reload(); m_mode = 0; m_died = 0;
    end else if (m_mode == 0) begin
      m_died = 0;
      if (run) m_mode = 1;
    end else if (m_mode == 2) begin
      m_died = 0; m_reload();
      m_mode = run ? 1 : 0;
    end else begin
      m_died = 0;
      if (!run) begin
        m_reload(); m_mode = 0;
      end else if (tick) begin
        hit = 0;
        for (int i = 0; i < N; i++)
          if (m_x[i] < 80 && m_x[i] + 16 > 64 && py_i < 400 && py_i + 24 > 380) hit = 1;
        if (hit) begin
          m_died = 1; m_mode = 2;
        end else begin
          passed = 0;
          for (int i = 0; i < N; i++) begin
            if (m_x[i] < spd) begin
              m_x[i] = m_x[i] + 640 - spd; passed++;
            end else begin
              m_x[i] = m_x[i] - spd;
            end
          end
          m_oc = (m_oc + passed > 2047) ? 2047 : m_oc + passed;
          m_div++;
          if (m_div == 6) begin
            m_div = 0;
            if (m_gt < 2047) m_gt++;
          end
        end
      end
    end
    e.gt = 11'(m_gt); e.oc = 11'(m_oc); e.died = m_died[0];
    for (int i = 0; i < N; i++) e.obs[11*i +: 11] = 11'(m_x[i]);
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      cmp("game_time",  64'(bus.game_time),  64'(e.gt));
      cmp("obj_count",  64'(bus.obj_count),  64'(e.oc));
      cmp("playerDied", 64'(bus.playerDied), 64'(e.died));
      cmp("obs_x",      64'(bus.obs_x),      64'(e.obs));
    end
  end

  function automatic int obs0();
    return int'(bus.obs_x[10:0]);
  endfunction

  initial begin
    int k;
    bus.run = 1'b0; bus.frame_tick = 1'b0; bus.level = 3'b001; bus.player_y = '0;

    step(1, 0, 0, 3'b001, 10'd0);
    step(1, 0, 0, 3'b001, 10'd0);
    cmp("reset_obs0", 64'(obs0()), 64'd639);
    cmp("reset_gt", 64'(bus.game_time), 64'd0);

    // Slow level: six frames make one game tick
    step(0, 1, 0, 3'b001, 10'd0);
    for (int i = 0; i < 6; i++) step(0, 1, 1, 3'b001, 10'd0);
    cmp("lvl1_obs0", 64'(obs0()), 64'd633);
    cmp("lvl1_gt", 64'(bus.game_time), 64'd1);
    cmp("lvl1_oc", 64'(bus.obj_count), 64'd0);

    // Fast level wrap of obstacle 0
    step(1, 0, 0, 3'b100, 10'd0);
    step(0, 1, 0, 3'b100, 10'd0);
    for (int i = 0; i < 213; i++) step(0, 1, 1, 3'b100, 10'd0);
    cmp("wrap_at_zero", 64'(obs0()), 64'd0);
    step(0, 1, 1, 3'b100, 10'd0);
    cmp("wrap_obs0", 64'(obs0()), 64'd637);
    cmp("wrap_oc", 64'(bus.obj_count), 64'd1);

    // Collision: bring obstacle 0 near the player, then stand on the ground
    step(1, 0, 0, 3'b010, 10'd0);
    step(0, 1, 0, 3'b010, 10'd0);
    k = 0;
    while (!(obs0() >= 70 && obs0() <= 79) && k < 400) begin
      step(0, 1, 1, 3'b010, 10'd0); k++;
    end
    cmp("preload_reached", 64'(k < 400), 64'd1);
    step(0, 1, 1, 3'b010, 10'd380);
    cmp("hit_died", 64'(bus.playerDied), 64'd1);
    step(0, 1, 0, 3'b010, 10'd380);
    cmp("dead_died_clear", 64'(bus.playerDied), 64'd0);
    cmp("dead_gt", 64'(bus.game_time), 64'd0);
    cmp("dead_oc", 64'(bus.obj_count), 64'd0);
    cmp("dead_obs0", 64'(obs0()), 64'd639);

    // Jumping player lets obstacle pass
    k = 0;
    while (bus.obj_count == 11'd0 && k < 400) begin
      step(0, 1, 1, 3'b010, 10'd300); k++;
    end
    cmp("jump_pass", 64'(bus.obj_count), 64'd1);

    // run falls together with a frame tick
    step(0, 0, 1, 3'b010, 10'd300);
    cmp("drop_gt", 64'(bus.game_time), 64'd0);
    cmp("drop_oc", 64'(bus.obj_count), 64'd0);
    cmp("drop_obs0", 64'(obs0()), 64'd639);

    // game_time saturation
    step(1, 0, 0, 3'b001, 10'd0);
    step(0, 1, 0, 3'b001, 10'd0);
    for (int i = 0; i < 2047 * 6 + 5; i++) step(0, 1, 1, 3'b001, 10'd0);
    cmp("sat_gt", 64'(bus.game_time), 64'd2047);
    for (int i = 0; i < 12; i++) step(0, 1, 1, 3'b001, 10'd0);
    cmp("sat_gt_hold", 64'(bus.game_time), 64'd2047);

    // Randomized play with occasional drops, resets, invalid levels and danger heights
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] lvl;
      logic [9:0] py;
      int r;
      r = int'($urandom_range(0, 3));
      lvl = (r == 0) ? 3'b001 : (r == 1) ? 3'b010 : (r == 2) ? 3'b100 : 3'($urandom);
      r = int'($urandom_range(0, 3));
      py = (r == 0) ? 10'($urandom) : (r == 1) ? 10'($urandom_range(350, 410)) : 10'd0;
      step($urandom_range(0, 499) == 0, $urandom_range(0, 99) != 0,
           $urandom_range(0, 1) == 1, lvl, py);
    end

    repeat (3) @(posedge clk);
    #3;
    cmp("queue_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
